trng_vn_collector: RTL
======================

Name: trng_vn_collector

Overview:
Downstream entropy stage and request sequencer for TRNG_CTRL. It repeatedly issues RNG commands, captures each 144-bit raw sample on Done, runs a serial Von Neumann debiaser over the 72 bit-pairs, and packs the output bits into 32-bit words. Words go into a small first-word-fall-through FIFO that the host pops. It also applies a basic stuck-sample health test and maintains error and timeout status.

Parameters:
SAMPLE_W, 144, raw sample width (must be even)
WORD_W, 32, packed output word width
FIFO_DEPTH, 4, output FIFO entries (power of 2)
TIMEOUT, 1024, clk cycles to wait for ctrl_done/ctrl_err before aborting

Ports:
clk  input  1  system clock (100 MHz)
rstn  input  1  asynchronous active-low reset
enable  input  1  level; 1 = keep harvesting
clr_status  input  1  pulse; clears health_fail, timeout_flag, err_cnt
ctrl_start  output  1  one-cycle start pulse to TRNG_CTRL
ctrl_cmd  output  2  command to TRNG_CTRL; constant RNG (2'b00)
ctrl_done  input  1  Done from TRNG_CTRL
ctrl_err  input  1  err from TRNG_CTRL
ctrl_mem_out  input  SAMPLE_W  MEM_OUT from TRNG_CTRL
rd_en  input  1  host pop; ignored when fifo_empty
rd_data  output  WORD_W  head of FIFO, valid while !fifo_empty
fifo_empty  output  1  FIFO empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held
health_fail  output  1  sticky; an all-0 or all-1 sample was seen
timeout_flag  output  1  sticky; TIMEOUT expired in WAIT
err_cnt  output  8  saturating count of ctrl_err events

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; ctrl_start=0; ctrl_cmd=2'b00; rd_data=0; fifo_empty=1; fifo_level=0; health_fail=0; timeout_flag=0; err_cnt=0. The partial word, bit count, pair index and timeout counter are cleared. Reset mid-sample discards everything.
- FSM states: IDLE, REQ, WAIT, CHECK, EXTRACT.
- IDLE -> REQ when enable=1 and fifo_level<FIFO_DEPTH.
- REQ: ctrl_start=1 for exactly one cycle, then go to WAIT and clear the timeout counter.
- WAIT:
  - ctrl_done=1: capture ctrl_mem_out into the sample register and go to CHECK.
  - ctrl_err=1 (priority over done when both are high): err_cnt+1, saturating at 255, then IDLE.
  - Counter reaches TIMEOUT-1: set timeout_flag, then IDLE.
- CHECK (1 cycle): if the sample is all-0 or all-1, set health_fail, discard the sample, and go to IDLE. Otherwise go to EXTRACT with pair index i=0.
- EXTRACT handles one pair per cycle: a=s[2i], b=s[2i+1].
  - If a!=b, shift a into the partial word at bit position bit_cnt (LSB first), then bit_cnt+1.
  - If a==b, no output.
  - When bit_cnt reaches WORD_W, push the word into the FIFO and set bit_cnt=0.
  - After i=71 is processed, go to IDLE. The partial word and bit_cnt persist across samples.
- FIFO full at push time: EXTRACT stalls. i, the partial word and bit_cnt are held until a pop frees a slot. A push and pop in the same cycle while full proceed (level unchanged).
- FIFO is FWFT: rd_data shows the head whenever not empty. rd_en with fifo_empty=1 has no effect. A simultaneous push and pop on an empty FIFO is not allowed; the pop is ignored and the push is kept.
- enable=0 stops only new requests. A sample already in WAIT, CHECK or EXTRACT completes.
- clr_status clears the sticky flags and err_cnt on the next edge. If it coincides with a set event, the set event wins.
- ctrl_cmd is always RNG. SET_VAR, WRITE and READ remain the host's business, muxed outside this block.

Decomposition:
- Shared package trng_pkg:
  - CMD codes: RNG=2'b00, SET_VAR=2'b01, WRITE=2'b10, READ=2'b11.
  - FSM state enum.
  - SAMPLE_W and WORD_W defaults.
- One sub-module, trng_word_fifo: a parameterised FWFT synchronous FIFO with push, pop, full, empty and level.

Test Plan:
- enable=1; ctrl_done after 20 cycles with mem_out={72{2'b01}}.
  - Expect ctrl_start to pulse once.
  - FIFO receives 0xFFFFFFFF twice; level=2; 8 bits remain partial.
  - A second identical sample completes word 3 = 0xFFFFFFFF after 24 pairs.
- mem_out={72{2'b10}} -> two words of 0x00000000. Next sample {72{2'b01}} -> the third word (8 leftover zeros then 24 ones) = 0xFFFFFF00.
- mem_out={36{4'b0011}} -> no words, health_fail=0. mem_out=all-ones -> health_fail=1, no words, FSM back to IDLE within 2 cycles.
- Fill the FIFO (4 entries) with rd_en=0 -> no ctrl_start while full. Mid-EXTRACT stall when full -> a pop resumes the stream with no bit lost or duplicated.
- ctrl_err at WAIT -> err_cnt=1 and a retry request follows. No done/err for 1024 cycles -> timeout_flag=1. clr_status -> both cleared.
- Assert rstn=0 mid-EXTRACT -> all outputs return to their reset values immediately; after release, the next sample packs from bit 0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared command codes, FSM states and width defaults for the TRNG harvesting path.
package trng_pkg;

    typedef enum logic [1:0] {
        CMD_RNG     = 2'b00,
        CMD_SET_VAR = 2'b01,
        CMD_WRITE   = 2'b10,
        CMD_READ    = 2'b11
    } trng_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_EXTRACT
    } vn_state_e;

    localparam int SAMPLE_W_DEF = 144;
    localparam int WORD_W_DEF   = 32;

endpackage

// File: rtl/trng_word_fifo.sv
// First-word-fall-through FIFO for packed entropy words; head is visible on rd_data while not empty.
module trng_word_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees the slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/trng_vn_collector.sv
// Requests raw samples from TRNG_CTRL, Von Neumann debiases them one pair per cycle and packs words into a FIFO.
module trng_vn_collector
    import trng_pkg::*;
#(
    parameter  int SAMPLE_W   = SAMPLE_W_DEF,
    parameter  int WORD_W     = WORD_W_DEF,
    parameter  int FIFO_DEPTH = 4,
    parameter  int TIMEOUT    = 1024,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic                clr_status,
    output logic                ctrl_start,
    output logic [1:0]          ctrl_cmd,
    input  logic                ctrl_done,
    input  logic                ctrl_err,
    input  logic [SAMPLE_W-1:0] ctrl_mem_out,
    input  logic                rd_en,
    output logic [WORD_W-1:0]   rd_data,
    output logic                fifo_empty,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                health_fail,
    output logic                timeout_flag,
    output logic [7:0]          err_cnt
);

    localparam int PAIRS  = SAMPLE_W / 2;
    localparam int IDX_W  = $clog2(PAIRS);
    localparam int SIDX_W = IDX_W + 1;
    localparam int BC_W   = $clog2(WORD_W);
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] PAIR_LAST = IDX_W'(PAIRS - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    vn_state_e           state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [IDX_W-1:0]    pair_idx_q;
    logic [BC_W-1:0]     bit_cnt_q;
    logic [WORD_W-1:0]   word_q, word_next;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [SIDX_W-1:0]   bit_lo, bit_hi;
    logic                vn_a, vn_b, vn_valid, word_done, stall;
    logic                fifo_full, fifo_push, sample_stuck, tmo_hit;
    logic                evt_err, evt_tmo, evt_stuck;

    assign ctrl_cmd = CMD_RNG;

    assign bit_lo       = {pair_idx_q, 1'b0};
    assign bit_hi       = {pair_idx_q, 1'b1};
    assign vn_a         = sample_q[bit_lo];
    assign vn_b         = sample_q[bit_hi];
    assign vn_valid     = (state_q == ST_EXTRACT) && (vn_a != vn_b);
    assign word_done    = vn_valid && (bit_cnt_q == BIT_LAST);
    // A completing word with nowhere to go freezes the whole extraction until the host pops.
    assign stall        = word_done && fifo_full && !rd_en;
    assign fifo_push    = word_done && !stall;
    assign sample_stuck = (&sample_q) || !(|sample_q);
    assign tmo_hit      = (tmo_cnt_q == TMO_LAST);

    assign evt_err   = (state_q == ST_WAIT) && ctrl_err;
    assign evt_tmo   = (state_q == ST_WAIT) && !ctrl_err && !ctrl_done && tmo_hit;
    assign evt_stuck = (state_q == ST_CHECK) && sample_stuck;

    always_comb begin
        word_next            = word_q;
        word_next[bit_cnt_q] = vn_a;
    end

    always_comb begin
        state_d    = state_q;
        ctrl_start = 1'b0;
        unique case (state_q)
            ST_IDLE:    if (enable && !fifo_full) state_d = ST_REQ;
            ST_REQ: begin
                ctrl_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl_err || evt_tmo) state_d = ST_IDLE;
                else if (ctrl_done)      state_d = ST_CHECK;
            end
            ST_CHECK:   state_d = sample_stuck ? ST_IDLE : ST_EXTRACT;
            ST_EXTRACT: if (!stall && pair_idx_q == PAIR_LAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The partial word and bit count deliberately survive between samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_q   <= '0;
            pair_idx_q <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_REQ:   tmo_cnt_q <= '0;
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (ctrl_done && !ctrl_err) sample_q <= ctrl_mem_out;
                end
                ST_CHECK: pair_idx_q <= '0;
                ST_EXTRACT: begin
                    if (!stall) begin
                        pair_idx_q <= pair_idx_q + IDX_W'(1);
                        if (vn_valid) begin
                            word_q    <= word_next;
                            bit_cnt_q <= word_done ? '0 : bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            health_fail  <= 1'b0;
            timeout_flag <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (evt_stuck)       health_fail <= 1'b1;
            else if (clr_status) health_fail <= 1'b0;

            if (evt_tmo)         timeout_flag <= 1'b1;
            else if (clr_status) timeout_flag <= 1'b0;

            if (evt_err) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (clr_status) begin
                err_cnt <= '0;
            end
        end
    end

    trng_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .wr_data (word_next),
        .pop     (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule
